pmem_uart_loader: RTL and testbench

PMEM_UART_LOADER -- requirements
Module: pmem_uart_loader

---
 rtl/pmem_uart_loader_if.sv | 8 +
 rtl/pmem_uart_loader.sv | 150 +++++++++++++++
 tb/tb_pmem_uart_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pmem_uart_loader_if.sv
// pmem_uart_loader_if: PMEM write port driven by the UART boot loader.
interface pmem_uart_loader_if;
    logic        ic1_c_axi_mst_wr_valid;
    logic [31:0] ic1_axi_mst_wr_data;
    logic [31:0] ic1_axi_mst_wr_addr;
    modport master (output ic1_c_axi_mst_wr_valid, ic1_axi_mst_wr_data, ic1_axi_mst_wr_addr);
    modport slave  (input  ic1_c_axi_mst_wr_valid, ic1_axi_mst_wr_data, ic1_axi_mst_wr_addr);
endinterface

// File: rtl/pmem_uart_loader.sv
// pmem_uart_loader: 8N1 UART receiver feeding a framed image (A5, len16, words) into PMEM.
module pmem_uart_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       c_sys_rst,
    input  logic                       uart_rx,
    pmem_uart_loader_if.master         wr,
    output logic                       c_cpu_rst,
    output logic                       boot_done,
    output logic                       boot_err
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_e;
    typedef enum logic [2:0] {WAIT_SYNC, LEN_LO, LEN_HI, DATA, DONE, ERR} ld_e;

    rx_e         rs_q, rs_d;
    ld_e         ls_q, ls_d;
    logic        s1_q, s2_q, prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bi_q, bi_d;
    logic [7:0]  sh_q, sh_d;
    logic        bv_q, bv_d, fe_q, fe_d;
    logic [15:0] len_q, len_d, wcnt_q, wcnt_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] asm_q, asm_d;
    logic        wv_q, wv_d;
    logic [31:0] wd_q, wd_d, wa_q, wa_d;

    wire half = cnt_q == 16'(CLKS_PER_BIT / 2 - 1);
    wire full = cnt_q == 16'(CLKS_PER_BIT - 1);

    always_comb begin
        rs_d = rs_q;
        cnt_d = cnt_q + 16'd1;
        bi_d = bi_q;
        sh_d = sh_q;
        bv_d = 1'b0;
        fe_d = 1'b0;
        case (rs_q)
            RX_IDLE: begin
                cnt_d = '0;
                rs_d = (prev_q && !s2_q) ? RX_START : RX_IDLE;
            end
            RX_START: if (half) begin
                cnt_d = '0;
                bi_d = '0;
                rs_d = s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (full) begin
                cnt_d = '0;
                sh_d = {s2_q, sh_q[7:1]};
                bi_d = bi_q + 3'd1;
                rs_d = (bi_q == 3'd7) ? RX_STOP : RX_DATA;
            end
            default: if (full) begin
                rs_d = RX_IDLE;
                bv_d = s2_q;
                fe_d = !s2_q;
            end
        endcase
    end

    // Byte/word progress is only meaningful in DATA; a write for the last word moves on to DONE.
    always_comb begin
        ls_d = ls_q;
        len_d = len_q;
        wcnt_d = wcnt_q;
        bcnt_d = bcnt_q;
        asm_d = asm_q;
        wv_d = 1'b0;
        wd_d = wd_q;
        wa_d = wa_q;
        case (ls_q)
            WAIT_SYNC: ls_d = fe_q ? ERR : (bv_q && sh_q == 8'hA5) ? LEN_LO : WAIT_SYNC;
            LEN_LO: if (fe_q) ls_d = ERR;
                else if (bv_q) begin
                    len_d = {len_q[15:8], sh_q};
                    ls_d = LEN_HI;
                end
            LEN_HI: if (fe_q) ls_d = ERR;
                else if (bv_q) begin
                    len_d = {sh_q, len_q[7:0]};
                    wcnt_d = '0;
                    bcnt_d = '0;
                    ls_d = ({sh_q, len_q[7:0]} == 16'd0) ? DONE : DATA;
                end
            DATA: if (fe_q) ls_d = ERR;
                else if (wv_q && wcnt_q == len_q) ls_d = DONE;
                else if (bv_q) begin
                    asm_d = {sh_q, asm_q[23:8]};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wv_d = 1'b1;
                        wd_d = {sh_q, asm_q};
                        wa_d = BASE_ADDR + {14'd0, wcnt_q, 2'b00};
                        wcnt_d = wcnt_q + 16'd1;
                    end
                end
            default: ls_d = ls_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (c_sys_rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            prev_q <= 1'b1;
            rs_q <= RX_IDLE;
            cnt_q <= '0;
            bi_q <= '0;
            sh_q <= '0;
            bv_q <= 1'b0;
            fe_q <= 1'b0;
            ls_q <= WAIT_SYNC;
            len_q <= '0;
            wcnt_q <= '0;
            bcnt_q <= '0;
            asm_q <= '0;
            wv_q <= 1'b0;
            wd_q <= '0;
            wa_q <= '0;
        end else begin
            s1_q <= uart_rx;
            s2_q <= s1_q;
            prev_q <= s2_q;
            rs_q <= rs_d;
            cnt_q <= cnt_d;
            bi_q <= bi_d;
            sh_q <= sh_d;
            bv_q <= bv_d;
            fe_q <= fe_d;
            ls_q <= ls_d;
            len_q <= len_d;
            wcnt_q <= wcnt_d;
            bcnt_q <= bcnt_d;
            asm_q <= asm_d;
            wv_q <= wv_d;
            wd_q <= wd_d;
            wa_q <= wa_d;
        end
    end

    assign wr.ic1_c_axi_mst_wr_valid = wv_q;
    assign wr.ic1_axi_mst_wr_data = wd_q;
    assign wr.ic1_axi_mst_wr_addr = wa_q;
    assign c_cpu_rst = ls_q != DONE;
    assign boot_done = ls_q == DONE;
    assign boot_err = ls_q == ERR;
endmodule

// File: tb/tb_pmem_uart_loader.sv
// tb_pmem_uart_loader: directed UART images against hand-computed PMEM strobes and status.
module tb_pmem_uart_loader;
    logic clk = 1'b0, c_sys_rst = 1'b1, uart_rx = 1'b1;
    logic c_cpu_rst, boot_done, boot_err;
    int errors = 0, checks = 0;
    logic [63:0] strobes[$];

    pmem_uart_loader_if wr();
    pmem_uart_loader #(.CLKS_PER_BIT(4), .BASE_ADDR(32'h100)) dut (
        .clk(clk), .c_sys_rst(c_sys_rst), .uart_rx(uart_rx), .wr(wr),
        .c_cpu_rst(c_cpu_rst), .boot_done(boot_done), .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!c_sys_rst && wr.ic1_c_axi_mst_wr_valid)
            strobes.push_back({wr.ic1_axi_mst_wr_addr, wr.ic1_axi_mst_wr_data});

    typedef struct {
        int          n;
        logic [95:0] b;
        int          bad;
        int          exp_n;
        logic [31:0] a0, d0, a1, d1;
        logic        done, err;
    } vec_t;
    vec_t v[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (4) @(negedge clk);
        end
        uart_rx = stop;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        c_sys_rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        c_sys_rst = 1'b0;
        strobes.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        v[0] = '{11, 96'hA5_02_00_13_00_00_00_93_00_10_00_00, -1, 2,
                 32'h100, 32'h0000_0013, 32'h104, 32'h0010_0093, 1'b1, 1'b0};
        v[1] = '{5, 96'h55_FF_A5_00_00_00_00_00_00_00_00_00, -1, 0,
                 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
        v[2] = '{11, 96'hA5_01_00_00_A5_01_00_11_22_33_44_00, 3, 0,
                 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
        v[3] = '{5, 96'hA5_00_00_00_A5_00_00_00_00_00_00_00, 3, 0,
                 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
        v[4] = '{8, 96'hA5_01_00_11_22_33_44_55_00_00_00_00, -1, 1,
                 32'h100, 32'h4433_2211, 32'h0, 32'h0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_valid", {63'd0, wr.ic1_c_axi_mst_wr_valid}, 64'd0);
        chk("rst_data", {32'd0, wr.ic1_axi_mst_wr_data}, 64'd0);
        chk("rst_addr", {32'd0, wr.ic1_axi_mst_wr_addr}, 64'd0);
        chk("rst_cpu_rst", {63'd0, c_cpu_rst}, 64'd1);
        chk("rst_done", {63'd0, boot_done}, 64'd0);
        chk("rst_err", {63'd0, boot_err}, 64'd0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            for (int j = 0; j < v[i].n; j++)
                send(v[i].b[95 - 8 * j -: 8], j != v[i].bad);
            repeat (10) @(negedge clk);
            chk($sformatf("v%0d_nstrobe", i), 64'(strobes.size()), 64'(v[i].exp_n));
            for (int k = 0; k < v[i].exp_n; k++)
                chk($sformatf("v%0d_strobe%0d", i, k), (k < strobes.size()) ? strobes[k] : '1,
                    (k == 0) ? {v[i].a0, v[i].d0} : {v[i].a1, v[i].d1});
            chk($sformatf("v%0d_done", i), {63'd0, boot_done}, {63'd0, v[i].done});
            chk($sformatf("v%0d_err", i), {63'd0, boot_err}, {63'd0, v[i].err});
            chk($sformatf("v%0d_cpu_rst", i), {63'd0, c_cpu_rst}, {63'd0, !v[i].done});
        end
        chk("hold_valid", {63'd0, wr.ic1_c_axi_mst_wr_valid}, 64'd0);
        chk("hold_data", {32'd0, wr.ic1_axi_mst_wr_data}, 64'h4433_2211);
        chk("hold_addr", {32'd0, wr.ic1_axi_mst_wr_addr}, 64'h100);

        do_reset();
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_nstrobe", 64'(strobes.size()), 64'd0);
        chk("glitch_err", {63'd0, boot_err}, 64'd0);
        chk("glitch_done", {63'd0, boot_done}, 64'd0);
        send(8'hA5, 1'b1);
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        chk("glitch_then_done", {63'd0, boot_done}, 64'd1);
        chk("glitch_then_err", {63'd0, boot_err}, 64'd0);

        do_reset();
        send(8'hA5, 1'b1);
        send(8'h01, 1'b1);
        send(8'h00, 1'b1);
        send(8'hEF, 1'b1);
        send(8'hBE, 1'b1);
        chk("midword_nstrobe", 64'(strobes.size()), 64'd0);
        do_reset();
        send(8'hA5, 1'b1);
        send(8'h01, 1'b1);
        send(8'h00, 1'b1);
        send(8'hEF, 1'b1);
        send(8'hBE, 1'b1);
        send(8'hAD, 1'b1);
        send(8'hDE, 1'b1);
        repeat (10) @(negedge clk);
        chk("reload_nstrobe", 64'(strobes.size()), 64'd1);
        chk("reload_strobe", (strobes.size() > 0) ? strobes[0] : '1, {32'h100, 32'hDEAD_BEEF});
        chk("reload_done", {63'd0, boot_done}, 64'd1);
        chk("reload_cpu_rst", {63'd0, c_cpu_rst}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
